// File: rtl/color_histogram.sv
// Per-bin histogram of colour-matching pixels inside the 128x104 inner frame of a QQVGA stream.
// Optional macro COLOR_HIST_RUN2_EN enables a two-pixel horizontal run noise filter.
module color_histogram (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof_i,
  input  logic        eof_i,
  input  logic        pxl_vld_i,
  input  logic [7:0]  pxl_col_i,
  input  logic [6:0]  pxl_row_i,
  input  logic        pxl_match_i,
  output logic [13:0] colorpxls_o,
  output logic [9:0]  colorpxls_bin0_o,
  output logic [9:0]  colorpxls_bin7_o,
  output logic [12:0] colorpxls_left_o,
  output logic [12:0] colorpxls_rght_o,
  output logic [12:0] colorpxls_bin012_o,
  output logic [12:0] colorpxls_bin567_o,
  output logic [12:0] colorpxls_bin01_o,
  output logic [12:0] colorpxls_bin67_o,
  output logic        new_frame_proc_o
);

  localparam int unsigned C_HIST_BINS       = 8;
  localparam int unsigned C_NB_HIST_VAL     = 10;
  localparam int unsigned C_NB_INFRAME_PXLS = 14;
  localparam int unsigned C_NB_SUM          = 13;
  localparam logic [7:0]  C_COL_LO          = 8'd16;
  localparam logic [7:0]  C_COL_HI          = 8'd143;
  localparam logic [6:0]  C_ROW_LO          = 7'd8;
  localparam logic [6:0]  C_ROW_HI          = 7'd111;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SUM} state_t;

  state_t                          state_q, state_d;
  logic [C_NB_HIST_VAL-1:0]        bin_q [C_HIST_BINS];
  logic [C_NB_HIST_VAL-1:0]        bin_d [C_HIST_BINS];
  logic [C_NB_INFRAME_PXLS-1:0]    total_q, total_d;
  logic [C_NB_INFRAME_PXLS-1:0]    colorpxls_q;
  logic [C_NB_HIST_VAL-1:0]        bin0_q, bin7_q;
  logic [C_NB_SUM-1:0]             left_q, rght_q, bin012_q, bin567_q, bin01_q, bin67_q;
  logic [C_NB_SUM-1:0]             sum01, sum67, sum012, sum567, sum_left, sum_rght;
  logic                            pulse_q;
  logic                            in_frame, acc_en, match_eff, hit;
  logic [2:0]                      bin_idx;

  assign in_frame = (pxl_col_i >= C_COL_LO) && (pxl_col_i <= C_COL_HI) &&
                    (pxl_row_i >= C_ROW_LO) && (pxl_row_i <= C_ROW_HI);
  assign bin_idx  = 3'((pxl_col_i - C_COL_LO) >> 4);
  // The sof_i cycle already belongs to the new frame, whatever state we are in.
  assign acc_en   = (state_q == S_ACC) || sof_i;

`ifdef COLOR_HIST_RUN2_EN
  logic run_q;

  // In raster order every in-frame row starts at column 16, so blocking that
  // column also covers the row change.
  assign match_eff = pxl_match_i && run_q && !sof_i && (pxl_col_i != C_COL_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         run_q <= 1'b0;
    else if (pxl_vld_i) run_q <= pxl_match_i;
    else if (sof_i)     run_q <= 1'b0;
  end
`else
  assign match_eff = pxl_match_i;
`endif

  assign hit = acc_en && pxl_vld_i && match_eff && in_frame;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sof_i) state_d = S_ACC;
      S_ACC:   if (sof_i) state_d = S_ACC;
               else if (eof_i) state_d = S_SUM;
      S_SUM:   state_d = sof_i ? S_ACC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < C_HIST_BINS; i++) begin
      bin_d[i] = sof_i ? '0 : bin_q[i];
      if (hit && (bin_idx == 3'(i)) && (bin_d[i] != '1)) bin_d[i] = bin_d[i] + 1'b1;
    end
    total_d = sof_i ? '0 : total_q;
    if (hit && (total_d != '1)) total_d = total_d + 1'b1;
  end

  assign sum01    = C_NB_SUM'(bin_q[0]) + C_NB_SUM'(bin_q[1]);
  assign sum67    = C_NB_SUM'(bin_q[6]) + C_NB_SUM'(bin_q[7]);
  assign sum012   = sum01 + C_NB_SUM'(bin_q[2]);
  assign sum567   = sum67 + C_NB_SUM'(bin_q[5]);
  assign sum_left = sum012 + C_NB_SUM'(bin_q[3]);
  assign sum_rght = sum567 + C_NB_SUM'(bin_q[4]);

  // NOTE: sequential state uses non-blocking '<='; the bin array is reset
  // explicitly because reset must leave every counter at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      total_q <= '0;
      for (int i = 0; i < C_HIST_BINS; i++) bin_q[i] <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      for (int i = 0; i < C_HIST_BINS; i++) bin_q[i] <= bin_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colorpxls_q <= '0;
      bin0_q      <= '0;
      bin7_q      <= '0;
      left_q      <= '0;
      rght_q      <= '0;
      bin012_q    <= '0;
      bin567_q    <= '0;
      bin01_q     <= '0;
      bin67_q     <= '0;
      pulse_q     <= 1'b0;
    end else begin
      pulse_q <= (state_q == S_SUM);
      if (state_q == S_SUM) begin
        colorpxls_q <= total_q;
        bin0_q      <= bin_q[0];
        bin7_q      <= bin_q[7];
        left_q      <= sum_left;
        rght_q      <= sum_rght;
        bin012_q    <= sum012;
        bin567_q    <= sum567;
        bin01_q     <= sum01;
        bin67_q     <= sum67;
      end
    end
  end

  assign colorpxls_o        = colorpxls_q;
  assign colorpxls_bin0_o   = bin0_q;
  assign colorpxls_bin7_o   = bin7_q;
  assign colorpxls_left_o   = left_q;
  assign colorpxls_rght_o   = rght_q;
  assign colorpxls_bin012_o = bin012_q;
  assign colorpxls_bin567_o = bin567_q;
  assign colorpxls_bin01_o  = bin01_q;
  assign colorpxls_bin67_o  = bin67_q;
  assign new_frame_proc_o   = pulse_q;

endmodule
